// File: rtl/bldc_reg_master.sv
// Bus initiator for the BLDC register block.
// Turns single host commands into one-cycle write/read strobes and captures the
// registered read data. While the host is idle it periodically reads the OUT
// register and publishes the decoded motor status.
//
// Handshakes: a transfer on cmd_* happens on the rising edge where
// cmd_valid && cmd_ready; a transfer on rsp_* happens on the rising edge where
// rsp_valid && rsp_ready. rsp_valid, rsp_err and rsp_rdata stay stable from
// assertion until that edge.
module bldc_reg_master #(
    parameter int unsigned POLL_PERIOD = 1000
) (
    input  logic        clk,
    input  logic        rst,
    // host command channel
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_addr,
    input  logic [31:0] cmd_wdata,
    // host response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    // register block bus
    output logic        write,
    output logic        read,
    output logic        addr,
    output logic [31:0] data_in,
    input  logic [31:0] data_out,
    // status polling
    input  logic        poll_en,
    output logic [7:0]  stat_vel,
    output logic [7:0]  stat_duty,
    output logic        stat_en,
    output logic [2:0]  stat_phase,
    output logic        stat_upd
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_RSP  = 3'd4;

    localparam logic [15:0] POLL_LAST = 16'(POLL_PERIOD - 1);

    logic [2:0]  state;
    logic        is_poll;
    logic [15:0] poll_cnt;
    logic        poll_pend;
    logic        accept;
    logic        poll_go;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    // A host command always wins over a pending poll; the poll stays pending.
    assign poll_go   = (state == S_IDLE) && poll_pend && !cmd_valid;

    // Free-running poll timer; a wrap raises at most one pending poll request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt  <= 16'd0;
            poll_pend <= 1'b0;
        end else if (!poll_en) begin
            poll_cnt  <= 16'd0;
            poll_pend <= 1'b0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt  <= 16'd0;
            poll_pend <= 1'b1;
        end else begin
            poll_cnt <= poll_cnt + 16'd1;
            if (poll_go) begin
                poll_pend <= 1'b0;
            end
        end
    end

    // Transaction FSM driving registered bus strobes, response and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            is_poll    <= 1'b0;
            write      <= 1'b0;
            read       <= 1'b0;
            addr       <= 1'b0;
            data_in    <= 32'd0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'd0;
            stat_vel   <= 8'd0;
            stat_duty  <= 8'd0;
            stat_en    <= 1'b0;
            stat_phase <= 3'd0;
            stat_upd   <= 1'b0;
        end else begin
            stat_upd <= 1'b0;
            case (state)
                S_IDLE: begin
                    addr <= 1'b0;
                    if (accept) begin
                        if (cmd_write && !cmd_addr) begin
                            state   <= S_WR;
                            write   <= 1'b1;
                            addr    <= 1'b0;
                            data_in <= cmd_wdata;
                        end else if (!cmd_write && cmd_addr) begin
                            state   <= S_RD;
                            read    <= 1'b1;
                            addr    <= 1'b1;
                            is_poll <= 1'b0;
                        end else begin
                            // CONFIG is write-only and OUT is read-only: answer
                            // with an error and keep the bus quiet.
                            state     <= S_RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end
                    end else if (poll_go) begin
                        state   <= S_RD;
                        read    <= 1'b1;
                        addr    <= 1'b1;
                        is_poll <= 1'b1;
                    end
                end
                S_WR: begin
                    write     <= 1'b0;
                    state     <= S_RSP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'd0;
                end
                S_RD: begin
                    read  <= 1'b0;
                    addr  <= 1'b0;
                    state <= S_CAP;
                end
                S_CAP: begin
                    // data_out was refreshed by the register block on the previous edge.
                    stat_vel   <= data_out[31:24];
                    stat_duty  <= data_out[23:16];
                    stat_en    <= data_out[15];
                    stat_phase <= data_out[13:11];
                    stat_upd   <= 1'b1;
                    is_poll    <= 1'b0;
                    if (is_poll) begin
                        state <= S_IDLE;
                    end else begin
                        state     <= S_RSP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= data_out;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'd0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    write     <= 1'b0;
                    read      <= 1'b0;
                    addr      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bldc_reg_master.sv
// Bench for bldc_reg_master: a behavioural register block, a transaction-level
// reference model of expected responses and status, and directed plus random steps.
module tb_bldc_reg_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic        cmd_addr = 1'b0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        write;
    logic        read;
    logic        addr;
    logic [31:0] data_in;
    logic [31:0] data_out = 32'd0;
    logic        poll_en = 1'b0;
    logic [7:0]  stat_vel;
    logic [7:0]  stat_duty;
    logic        stat_en;
    logic [2:0]  stat_phase;
    logic        stat_upd;

    int n_assert = 0;
    int n_fail = 0;
    int n_wr = 0;
    int n_rd = 0;
    int cyc = 0;
    logic wr_prev = 1'b0;
    logic rd_prev = 1'b0;

    logic [31:0] reg_cfg = 32'd0;   // register block CONFIG contents
    logic [2:0]  phase = 3'd0;      // register block phase_state input
    logic [31:0] ref_cfg = 32'd0;   // what the host believes CONFIG holds
    logic [31:0] last_wd = 32'd0;
    logic [31:0] exp_q[$];

    bldc_reg_master #(.POLL_PERIOD(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata),
        .write(write), .read(read), .addr(addr), .data_in(data_in),
        .data_out(data_out),
        .poll_en(poll_en), .stat_vel(stat_vel), .stat_duty(stat_duty),
        .stat_en(stat_en), .stat_phase(stat_phase), .stat_upd(stat_upd)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register block: CONFIG captured on write, registered OUT on read with phase in [13:11].
    always @(posedge clk) begin
        if (write && addr == 1'b0) reg_cfg <= data_in;
        if (read && addr == 1'b1) data_out <= {reg_cfg[31:14], phase, reg_cfg[10:0]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // OUT value the host expects: the config it wrote with the live phase overlaid.
    function automatic logic [31:0] model_out();
        logic [31:0] v;
        v = ref_cfg & ~(32'h7 << 11);
        return v | ({29'd0, phase} << 11);
    endfunction

    // Monitor: strobe rules and the status scoreboard.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            wr_prev = 1'b0;
            rd_prev = 1'b0;
        end else begin
            check("wr_rd_excl", 32'(write && read), 32'd0);
            check("wr_one_cycle", 32'(write && wr_prev), 32'd0);
            check("rd_one_cycle", 32'(read && rd_prev), 32'd0);
            if (write) n_wr++;
            if (read) begin
                n_rd++;
                check("rd_addr", 32'(addr), 32'd1);
                exp_q.push_back(model_out());
            end
            if (stat_upd) begin
                if (exp_q.size() == 0) begin
                    check("stat_upd_spurious", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("stat_vel", 32'(stat_vel), 32'(e[31:24]));
                    check("stat_duty", 32'(stat_duty), 32'(e[23:16]));
                    check("stat_en", 32'(stat_en), 32'(e[15]));
                    check("stat_phase", 32'(stat_phase), 32'(e[13:11]));
                end
            end
            wr_prev = write;
            rd_prev = read;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_write"}, 32'(write), 32'd0);
        check({tag, "_read"}, 32'(read), 32'd0);
        check({tag, "_addr"}, 32'(addr), 32'd0);
        check({tag, "_data_in"}, data_in, 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_stat"}, {13'd0, stat_vel, stat_duty, stat_en, stat_phase}, 32'd0);
        check({tag, "_stat_upd"}, 32'(stat_upd), 32'd0);
    endtask

    // One host command, response held for 'delay' cycles before acceptance.
    task automatic do_cmd(input logic w, input logic a, input logic [31:0] wd, input int delay);
        int wr0, rd0;
        logic legal, is_wr, is_rd;
        logic [31:0] exp_rdata;
        is_wr = w && (a == 1'b0);
        is_rd = !w && (a == 1'b1);
        legal = is_wr || is_rd;
        exp_rdata = is_rd ? model_out() : 32'd0;
        wr0 = n_wr;
        rd0 = n_rd;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr = a;
        cmd_wdata = wd;
        step();
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        if (is_wr) begin
            ref_cfg = wd;
            last_wd = wd;
            check("wr_strobe", 32'(write), 32'd1);
            check("wr_addr", 32'(addr), 32'd0);
            check("wr_data_in", data_in, wd);
            check("wr_rsp_early", 32'(rsp_valid), 32'd0);
            step();
            check("wr_strobe_drop", 32'(write), 32'd0);
        end else if (is_rd) begin
            check("rd_strobe", 32'(read), 32'd1);
            check("rd_rsp_early", 32'(rsp_valid), 32'd0);
            step();
            check("rd_strobe_drop", 32'(read), 32'd0);
            check("rd_rsp_cap", 32'(rsp_valid), 32'd0);
            step();
            check("rd_stat_upd", 32'(stat_upd), 32'd1);
        end else begin
            check("ill_no_strobe", 32'(write || read), 32'd0);
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_err", 32'(rsp_err), 32'(!legal));
        check("rsp_rdata", rsp_rdata, exp_rdata);
        for (int i = 0; i < delay; i++) begin
            step();
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, exp_rdata);
            check("bp_rsp_err", 32'(rsp_err), 32'(!legal));
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_no_strobe", 32'(write || read), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_done_valid", 32'(rsp_valid), 32'd0);
        check("rsp_done_ready", 32'(cmd_ready), 32'd1);
        check("idle_addr", 32'(addr), 32'd0);
        check("data_in_hold", data_in, last_wd);
        check("wr_pulses", 32'(n_wr - wr0), 32'(is_wr));
        check("rd_pulses", 32'(n_rd - rd0), 32'(is_rd));
    endtask

    task automatic wait_read(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (read) begin
                c = cyc;
                break;
            end
        end
        check("poll_read_timeout", 32'(c != -1), 32'd1);
    endtask

    initial begin
        int c1, c2, c3, p;
        logic [31:0] wd;

        // reset state
        repeat (3) step();
        check_outs_zero("reset");
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        step();

        // directed write then read with phase 5
        phase = 3'd5;
        do_cmd(1'b1, 1'b0, 32'h3C80_8000, 0);
        check("regblk_cfg", reg_cfg, 32'h3C80_8000);
        do_cmd(1'b0, 1'b1, 32'd0, 0);
        check("read_const", 32'(n_rd), 32'd1);
        check("stat_phase_const", 32'(stat_phase), 32'd5);
        check("stat_vel_const", 32'(stat_vel), 32'h3C);

        // illegal accesses
        do_cmd(1'b0, 1'b0, 32'd0, 0);
        do_cmd(1'b1, 1'b1, 32'hDEAD_BEEF, 1);
        check("regblk_cfg_kept", reg_cfg, 32'h3C80_8000);

        // backpressure on a read
        do_cmd(1'b0, 1'b1, 32'd0, 10);

        // random commands, phase and response delay
        for (int i = 0; i < 30; i++) begin
            phase = 3'($urandom_range(0, 7));
            do_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                   int'($urandom_range(0, 4)));
        end

        // reset during WR
        wd = $urandom;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 1'b0; cmd_wdata = wd;
        step();
        cmd_valid = 1'b0;
        check("rstwr_strobe", 32'(write), 32'd1);
        #1 rst = 1'b1;
        #1 check_outs_zero("rstwr");
        step();
        rst = 1'b0;
        exp_q.delete();
        last_wd = 32'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstwr_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("rstwr_cfg_kept", reg_cfg, ref_cfg);
        do_cmd(1'b1, 1'b0, $urandom, 0);

        // reset during CAP
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("rstcap_strobe", 32'(read), 32'd1);
        step();
        #1 rst = 1'b1;
        #1 check_outs_zero("rstcap");
        step();
        rst = 1'b0;
        exp_q.delete();
        last_wd = 32'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstcap_no_rsp", 32'(rsp_valid || stat_upd), 32'd0);
        end
        phase = 3'($urandom_range(0, 7));
        do_cmd(1'b0, 1'b1, 32'd0, 2);

        // periodic polling, period 8
        p = cyc;
        poll_en = 1'b1;
        wait_read(c1);
        check("poll_first", 32'(c1 - p), 32'd9);
        phase = 3'($urandom_range(0, 7));
        wait_read(c2);
        check("poll_period_1", 32'(c2 - c1), 32'd8);
        phase = 3'($urandom_range(0, 7));
        wait_read(c3);
        check("poll_period_2", 32'(c3 - c2), 32'd8);

        // host command collides with a due poll; poll follows the response
        repeat (7) step();
        do_cmd(1'b1, 1'b0, $urandom, 0);
        step();
        check("poll_after_rsp", 32'(read), 32'd1);

        // disable polling: the running poll completes, then the bus stays quiet
        poll_en = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 20; i++) begin
            step();
            check("poll_off_quiet", 32'(read), 32'd0);
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
